delay_tap_reader: RTL and testbench

- RAM-backed circular delay line with NTAPS runtime-programmable read taps.
- Complements the fixed shift-register delay used in the comb filters, which gives one output at a fixed LEN.
- This block gives several outputs per audio sample, each at its own delay, for multi-tap echo and early-reflection reverb.
- Sits between the voice mixer output (write side) and the reverb summing stage (reader side, valid/ready handshake).

---
 rtl/delay_tap_reader_pkg.sv | 28 ++
 rtl/dtr_ram.sv | 43 ++++
 rtl/delay_tap_reader.sv | 193 +++++++++++++++++++
 tb/tb_delay_tap_reader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_tap_reader_pkg.sv
// ---------------------------------------------------------------------------
// delay_tap_reader_pkg
//
// Shared audio types for the multi-tap delay reader.
//   sample_t     : default-width audio sample (12 bits)
//   tap_state_t  : reader sequencing states CLEAR / IDLE / RD / OUT
//   tap_w()      : width of a tap index for a given tap count (minimum 1)
// ---------------------------------------------------------------------------
package delay_tap_reader_pkg;

   localparam int DEFAULT_WIDTH = 12;

   typedef logic [DEFAULT_WIDTH-1:0] sample_t;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      RD    = 2'd2,
      OUT   = 2'd3
   } tap_state_t;

   // A single tap still needs a one-bit index so the port never collapses
   // to zero width.
   function automatic int tap_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dtr_ram.sv
// ---------------------------------------------------------------------------
// dtr_ram
//
// Single-port synchronous RAM, LEN x WIDTH, one-cycle read latency.
// Written in the plain form synthesis tools map onto block RAM.
//
// Ports:
//   clk    in   system clock
//   en     in   port enable; when low the read register holds its value
//   we     in   write enable (only meaningful with en)
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data from the last enabled read
// ---------------------------------------------------------------------------
module dtr_ram #(
   parameter int WIDTH = 12,
   parameter int LEN   = 2048,
   localparam int AW   = $clog2(LEN)
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [LEN];

   // Write or read on an enabled cycle. The read register is only updated
   // by a read, so the tap reader can present rdata for as long as the
   // consumer stalls without re-reading.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/delay_tap_reader.sv
// ---------------------------------------------------------------------------
// delay_tap_reader
//
// RAM-backed circular delay line with NTAPS runtime-programmable read taps.
// Each accepted sample strobe writes one sample and then streams NTAPS
// delayed samples out over a valid/ready handshake, one tap every two
// cycles when the consumer never stalls.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset (restarts the RAM clear)
//   enable       in   sample strobe, accepted only when busy is low
//   in           in   input sample [WIDTH]
//   delay        in   packed tap delays, tap k at [k*AW +: AW]
//   tap_data     out  delayed sample for the current tap
//   tap_idx      out  index of the current tap
//   tap_valid    out  tap_data / tap_idx valid
//   tap_ready    in   consumer accepts the current tap
//   busy         out  clearing or sequencing taps; enable is dropped
//   done         out  one-cycle pulse after the last tap handshake
//   overrun_cnt  out  saturating count of dropped enables
//                     (only when DELAY_TAP_OVERRUN_EN is defined)
//
// Optional feature macro: DELAY_TAP_OVERRUN_EN
// LEN must be a power of two and at least 4.
// ---------------------------------------------------------------------------
module delay_tap_reader
   import delay_tap_reader_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int LEN   = 2048,
   parameter int NTAPS = 4,
   localparam int AW   = $clog2(LEN),
   localparam int TW   = tap_w(NTAPS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [WIDTH-1:0]    in,
   input  logic [NTAPS*AW-1:0] delay,
   output logic [WIDTH-1:0]    tap_data,
   output logic [TW-1:0]       tap_idx,
   output logic                tap_valid,
   input  logic                tap_ready,
   output logic                busy,
   output logic                done
`ifdef DELAY_TAP_OVERRUN_EN
   ,
   output logic [7:0]          overrun_cnt
`endif
);

   localparam logic [TW-1:0] LAST_TAP = TW'(NTAPS - 1);
   localparam logic [AW-1:0] LAST_ADR = AW'(LEN - 1);

   tap_state_t          state;
   logic [AW-1:0]       wp;
   logic [AW-1:0]       clr_cnt;
   logic [TW-1:0]       k;
   logic [WIDTH-1:0]    s_cur;
   logic [NTAPS*AW-1:0] d_reg;
   logic                bypass;

   logic [AW-1:0]       d_k;
   logic [AW-1:0]       rd_addr;
   logic                ram_en;
   logic                ram_we;
   logic [AW-1:0]       ram_addr;
   logic [WIDTH-1:0]    ram_wdata;
   logic [WIDTH-1:0]    ram_q;

   // wp has already advanced past the sample written at accept time, so the
   // tap address is taken relative to wp-1; the AW-bit subtraction gives the
   // modulo-LEN wrap for free.
   assign d_k     = d_reg[int'(k)*AW +: AW];
   assign rd_addr = wp - AW'(1) - d_k;

   // The single RAM port is shared by the power-up clear, the sample write
   // and the tap reads; the state machine guarantees they never collide.
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = rd_addr;
      ram_wdata = '0;
      case (state)
         CLEAR: begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = clr_cnt;
         end
         IDLE: begin
            if (enable) begin
               ram_en    = 1'b1;
               ram_we    = 1'b1;
               ram_addr  = wp;
               ram_wdata = in;
            end
         end
         RD: begin
            ram_en = 1'b1;
         end
         default: begin
         end
      endcase
   end

   dtr_ram #(
      .WIDTH (WIDTH),
      .LEN   (LEN)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_q)
   );

   // Sequencer: clear the whole buffer after reset so early taps read
   // silence, then per accepted strobe alternate RD (issue RAM read) and
   // OUT (present tap until the consumer takes it) for every tap. A zero
   // delay tap would read the address being written this very strobe, so
   // it is served from the latched sample instead of the RAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         wp      <= '0;
         clr_cnt <= '0;
         k       <= '0;
         s_cur   <= '0;
         d_reg   <= '0;
         bypass  <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            CLEAR: begin
               clr_cnt <= clr_cnt + AW'(1);
               if (clr_cnt == LAST_ADR) begin
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (enable) begin
                  s_cur <= in;
                  d_reg <= delay;
                  k     <= '0;
                  wp    <= wp + AW'(1);
                  state <= RD;
               end
            end
            RD: begin
               bypass <= (d_k == '0);
               state  <= OUT;
            end
            OUT: begin
               if (tap_ready) begin
                  if (k == LAST_TAP) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     k     <= k + TW'(1);
                     state <= RD;
                  end
               end
            end
            default: begin
               state <= CLEAR;
            end
         endcase
      end
   end

   // Outputs decode straight from registered state so they stay glitch-free
   // and hold steady through a consumer stall.
   assign tap_valid = (state == OUT);
   assign tap_idx   = (state == OUT) ? k : '0;
   assign tap_data  = (state == OUT) ? (bypass ? s_cur : ram_q) : '0;
   assign busy      = (state != IDLE);

`ifdef DELAY_TAP_OVERRUN_EN
   // Count strobes that arrive while the block cannot take them; saturate
   // so a long overload never wraps back to a small, misleading value.
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_cnt <= '0;
      end else if (enable && busy && (overrun_cnt != 8'hFF)) begin
         overrun_cnt <= overrun_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_delay_tap_reader.sv
// ---------------------------------------------------------------------------
// tb_delay_tap_reader
//
// Scoreboard bench for delay_tap_reader (LEN=16, NTAPS=4, WIDTH=12).
// Stimulus pushes hand-computed expected taps into a queue; a monitor pops
// and compares on every tap handshake.
// ---------------------------------------------------------------------------
module tb_delay_tap_reader;

   localparam int WIDTH = 12;
   localparam int LEN   = 16;
   localparam int NTAPS = 4;
   localparam int AW    = 4;
   localparam int TW    = 2;

   typedef struct {
      logic [TW-1:0]    idx;
      logic [WIDTH-1:0] data;
      int               cyc;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                enable;
   logic [WIDTH-1:0]    in_s;
   logic [NTAPS*AW-1:0] delay;
   logic [WIDTH-1:0]    tap_data;
   logic [TW-1:0]       tap_idx;
   logic                tap_valid;
   logic                tap_ready;
   logic                busy;
   logic                done;
`ifdef DELAY_TAP_OVERRUN_EN
   logic [7:0]          overrun_cnt;
`endif

   exp_t exp_q[$];
   int   cyc = 0;
   int   done_cnt = 0;
   int   vec_count = 0;
   int   miss_count = 0;

   delay_tap_reader #(
      .WIDTH (WIDTH),
      .LEN   (LEN),
      .NTAPS (NTAPS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .in          (in_s),
      .delay       (delay),
      .tap_data    (tap_data),
      .tap_idx     (tap_idx),
      .tap_valid   (tap_valid),
      .tap_ready   (tap_ready),
      .busy        (busy),
      .done        (done)
`ifdef DELAY_TAP_OVERRUN_EN
      ,
      .overrun_cnt (overrun_cnt)
`endif
   );

   // Free-running clock and a cycle counter used for latency checks.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Count done pulses on the quiet edge.
   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
   end

   // Single comparison helper shared by the directed checks and the monitor.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vec_count++;
      if (actual !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: every accepted tap must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && tap_valid && tap_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_tap", 32'(tap_data), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("tap_idx", 32'(tap_idx), 32'(e.idx));
            checkOutput("tap_data", 32'(tap_data), 32'(e.data));
            if (e.cyc >= 0) checkOutput("tap_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   function automatic logic [NTAPS*AW-1:0] packDelays(input int d0, input int d1,
                                                      input int d2, input int d3);
      logic [NTAPS*AW-1:0] p;
      p = {AW'(d3), AW'(d2), AW'(d1), AW'(d0)};
      return p;
   endfunction

   // Wait, bounded, until the block can accept a strobe.
   task automatic waitIdle();
      int n;
      n = 0;
      while (busy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy) checkOutput("idle_timeout", 32'(busy), 32'd0);
   endtask

   // Wait, bounded, for the done pulse; returns the cycle it was seen in.
   task automatic waitDone(output int t);
      int n;
      n = 0;
      t = -1;
      while (n < 200) begin
         if (done) begin
            t = cyc;
            break;
         end
         @(posedge clk); #1;
         n++;
      end
      if (t < 0) checkOutput("done_timeout", 32'd0, 32'd1);
   endtask

   // Issue one accepted strobe and queue its four expected taps.
   task automatic applyStimulus(input logic [WIDTH-1:0] s, input logic [NTAPS*AW-1:0] d,
                                input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                                input logic [WIDTH-1:0] e2, input logic [WIDTH-1:0] e3,
                                input bit timed, output int t);
      logic [WIDTH-1:0] ev [NTAPS];
      waitIdle();
      ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
      t = cyc;
      for (int k = 0; k < NTAPS; k++) begin
         exp_t e;
         e.idx  = TW'(k);
         e.data = ev[k];
         e.cyc  = timed ? (t + 2 + 2 * k) : -1;
         exp_q.push_back(e);
      end
      enable = 1'b1;
      in_s   = s;
      delay  = d;
      @(posedge clk); #1;
      enable = 1'b0;
   endtask

   // Strobe regardless of busy, used to prove dropped enables are ignored.
   task automatic pulseEnable(input logic [WIDTH-1:0] s);
      enable = 1'b1;
      in_s   = s;
      @(posedge clk); #1;
      enable = 1'b0;
   endtask

   // Expected tap for filler strobe n with delays {0,1,2,3}: the sample
   // written k strobes earlier, 0x123 before the fillers, zero before that.
   function automatic logic [WIDTH-1:0] fillerExp(input int n, input int k);
      if (n - k >= 1) return WIDTH'(n - k);
      if (n - k == 0) return 12'h123;
      return '0;
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t;
      int td;
      int n;
      int dc;

      rst       = 1'b1;
      enable    = 1'b0;
      in_s      = '0;
      delay     = '0;
      tap_ready = 1'b1;

      // Reset state.
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("rst_tap_valid", 32'(tap_valid), 32'd0);
      checkOutput("rst_tap_idx", 32'(tap_idx), 32'd0);
      checkOutput("rst_tap_data", 32'(tap_data), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd1);
      rst = 1'b0;

      // Strobe during CLEAR must be dropped.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("clear_busy", 32'(busy), 32'd1);
      pulseEnable(12'h777);

      // First strobe: zero-delay bypass, cleared history, exact latency.
      applyStimulus(12'h123, packDelays(0, 1, 5, 15), 12'h123, 12'h000, 12'h000, 12'h000, 1'b1, t);
      waitDone(td);
      checkOutput("done_cycle", 32'(td), 32'(t + 2 * NTAPS + 1));
      checkOutput("done_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      checkOutput("done_pulse_width", 32'(done), 32'd0);

      // Fillers n=1..20 then a wrap-around read set.
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(WIDTH'(i), packDelays(0, 1, 2, 3), fillerExp(i, 0), fillerExp(i, 1),
                       fillerExp(i, 2), fillerExp(i, 3), 1'b0, t);
      end
      applyStimulus(12'd21, packDelays(1, 2, LEN - 1, 3), 12'd20, 12'd19, 12'd6, 12'd18, 1'b0, t);

      // Consumer stall on tap1: outputs must hold for five cycles.
      applyStimulus(12'd22, packDelays(0, 1, 2, 3), 12'd22, 12'd21, 12'd20, 12'd19, 1'b0, t);
      repeat (2) @(posedge clk);
      #1;
      tap_ready = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         checkOutput("stall_valid", 32'(tap_valid), 32'd1);
         checkOutput("stall_idx", 32'(tap_idx), 32'd1);
         checkOutput("stall_data", 32'(tap_data), 32'd21);
         @(posedge clk); #1;
      end
      tap_ready = 1'b1;

      // Strobe during OUT is dropped; the next strobe proves wp did not move.
      applyStimulus(12'd23, packDelays(0, 1, 2, 3), 12'd23, 12'd22, 12'd21, 12'd20, 1'b0, t);
      pulseEnable(12'hABC);
      applyStimulus(12'd24, packDelays(1, 2, 3, 4), 12'd23, 12'd22, 12'd21, 12'd20, 1'b0, t);
      waitDone(td);
`ifdef DELAY_TAP_OVERRUN_EN
      checkOutput("overrun_cnt", 32'(overrun_cnt), 32'd2);
`endif

      // Reset while tap2 is presented: sequence aborts, buffer re-clears.
      applyStimulus(12'd25, packDelays(0, 1, 2, 3), 12'd25, 12'd24, 12'd23, 12'd22, 1'b0, t);
      repeat (4) @(posedge clk);
      #1;
      tap_ready = 1'b0;
      @(posedge clk); #1;
      checkOutput("pre_rst_idx", 32'(tap_idx), 32'd2);
      checkOutput("pre_rst_data", 32'(tap_data), 32'd23);
      checkOutput("pending_taps", 32'(exp_q.size()), 32'd2);
      exp_q.delete();
      dc  = done_cnt;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("abort_valid", 32'(tap_valid), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd1);
      tap_ready = 1'b1;
      n = 1;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         if (busy) n++;
      end
      checkOutput("clear_cycles", 32'(n), 32'(LEN));
      checkOutput("abort_no_done", 32'(done_cnt), 32'(dc));

      // After the re-clear every non-zero delay reads silence.
      applyStimulus(12'h0AA, packDelays(1, 2, 3, 15), 12'h000, 12'h000, 12'h000, 12'h000, 1'b0, t);
      waitDone(td);
      @(posedge clk); #1;
      checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
